// File: rtl/input_wishbone.sv
// -----------------------------------------------------------------------------
// input_wishbone
//   Wishbone slave that brings the board inputs (16 slide switches, 5 push
//   buttons) into the SoC. Inputs pass through a two-flop synchroniser and a
//   tick-based debouncer. Debounced button rising edges are latched in a
//   write-1-to-clear EDGE register that drives a level interrupt through a
//   per-bit enable mask.
//
//   Register map (ADR_I[3:2]):
//     0x0 SW     RO    [15:0] debounced switches
//     0x4 BTN    RO    [4:0]  debounced buttons
//     0x8 EDGE   W1C   [4:0]  button rise latch ([20:5] switch change latch
//                             when INPUT_SWITCH_EDGE_EN is defined)
//     0xC IRQ_EN RW    same width as EDGE
//
//   Optional feature macro: INPUT_SWITCH_EDGE_EN
//
// Ports:
//   CLK_I     system clock
//   RST_I     synchronous active-high reset
//   CYC_I     Wishbone cycle
//   STB_I     Wishbone strobe
//   WE_I      write enable
//   ADR_I     byte address, bits [3:2] decoded
//   DAT_I     write data
//   DAT_O     registered read data
//   ACK_O     registered single-cycle acknowledge
//   I_switch  asynchronous slide switches
//   I_button  asynchronous push buttons
//   O_irq     registered level interrupt
// -----------------------------------------------------------------------------
module input_wishbone #(
  parameter int CLOCKFREQ        = 100000000,
  parameter int SAMPLE_HZ        = 1000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [3:0]  ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  input  logic [15:0] I_switch,
  input  logic [4:0]  I_button,
  output logic        O_irq
);

  localparam int TICK_DIV = CLOCKFREQ / SAMPLE_HZ;
  localparam int PW       = $clog2(TICK_DIV);
  localparam int CW       = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam int NIN      = 21;
`ifdef INPUT_SWITCH_EDGE_EN
  localparam int EW       = 21;
`else
  localparam int EW       = 5;
`endif

  // Input vector layout: switches in [15:0], buttons in [20:16]
  logic [NIN-1:0] r_sync1;
  logic [NIN-1:0] r_sync2;
  logic [NIN-1:0] r_deb;
  logic [CW-1:0]  r_cnt [NIN];
  logic [PW-1:0]  r_presc;
  logic [EW-1:0]  r_edge;
  logic [EW-1:0]  r_irq_en;

  logic           w_tick;
  logic [NIN-1:0] w_accept;
  logic [4:0]     w_btn_rise;
  logic [EW-1:0]  w_set;
  logic [EW-1:0]  w_clr;
  logic           w_req;
  logic           w_wr;
  logic [31:0]    w_rdata;
  logic           w_unused;

  assign w_unused = ^{ADR_I[1:0], DAT_I[31:EW]};

  // Synchroniser
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {I_button, I_switch};
      r_sync2 <= r_sync1;
    end
  end

  // Prescaler: tick fires in the last count of each sample period
  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge CLK_I) begin
    if (RST_I)       r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // A bit is accepted on the tick that would bring its count to
  // DEBOUNCE_SAMPLES, so the level flips and the counter clears together.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NIN; i++) begin
      w_accept[i] = w_tick && (r_sync2[i] != r_deb[i]) &&
                    (r_cnt[i] == CW'(DEBOUNCE_SAMPLES - 1));
    end
  end

  // Debounce
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_deb <= '0;
      for (int i = 0; i < NIN; i++) r_cnt[i] <= '0;
    end else if (w_tick) begin
      for (int i = 0; i < NIN; i++) begin
        if (w_accept[i]) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else if (r_sync2[i] != r_deb[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Event sources, aligned with the cycle in which the debounced level changes
  assign w_btn_rise = w_accept[20:16] & r_sync2[20:16];
`ifdef INPUT_SWITCH_EDGE_EN
  assign w_set = {w_accept[15:0], w_btn_rise};
`else
  assign w_set = w_btn_rise;
`endif

  // Bus decode; a request is blocked in the ACK cycle
  assign w_req = CYC_I & STB_I & ~ACK_O;
  assign w_wr  = w_req & WE_I;
  assign w_clr = (w_wr && ADR_I[3:2] == 2'd2) ? DAT_I[EW-1:0] : '0;

  // Edge latch and enable; a new event wins over a simultaneous clear
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_edge   <= '0;
      r_irq_en <= '0;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_set;
      if (w_wr && ADR_I[3:2] == 2'd3) r_irq_en <= DAT_I[EW-1:0];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (ADR_I[3:2])
      2'd0: w_rdata[15:0]   = r_deb[15:0];
      2'd1: w_rdata[4:0]    = r_deb[20:16];
      2'd2: w_rdata[EW-1:0] = r_edge;
      2'd3: w_rdata[EW-1:0] = r_irq_en;
      default: w_rdata = '0;
    endcase
  end

  // Response and interrupt registers
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ACK_O <= 1'b0;
      DAT_O <= '0;
      O_irq <= 1'b0;
    end else begin
      ACK_O <= w_req;
      if (w_req && !WE_I) DAT_O <= w_rdata;
      O_irq <= |(r_edge & r_irq_en);
    end
  end

endmodule
